// File: rtl/move_arbiter.sv
// move_arbiter: sequencer and arbiter for the Connect-4 board write port.
// It accepts column-drop requests from three sources (local buttons, the
// Arduino link and the random-move generator) and grants them with the fixed
// priority random > local > Arduino. It scans the granted column bottom-up in
// the live grid and issues a single-cycle write for the landing cell.
// A full column or an out-of-range column gives a reject pulse instead.
//
// Optional feature macro: MOVE_ARB_PENDING_EN. When it is defined, a one-deep
// buffer keeps the best eligible request that arrives while busy.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   turn_player     turn owner (01 P1, 10 P2; 00/11 block all requests)
//   loc_req/loc_col local request pulse and column (eligible only on P1 turn)
//   ard_req/ard_col Arduino request pulse and column (eligible only on P2 turn)
//   rnd_req/rnd_col random request pulse and column (eligible on either turn)
//   grid_in         board contents, cell (r,c) at [(r*COLS+c)*2 +: 2]
//   wr_en           single-cycle board write strobe
//   wr_row/wr_col   landing cell
//   wr_cell         code to write (turn_player latched at grant)
//   grant_src       active source: 00 none, 01 local, 10 Arduino, 11 random
//   busy            high outside IDLE
//   move_done       pulse after a successful write
//   move_reject     pulse for a full or out-of-range column
module move_arbiter #(
  parameter int ROWS = 6,
  parameter int COLS = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             turn_player,
  input  logic                   loc_req,
  input  logic [2:0]             loc_col,
  input  logic                   ard_req,
  input  logic [2:0]             ard_col,
  input  logic                   rnd_req,
  input  logic [2:0]             rnd_col,
  input  logic [ROWS*COLS*2-1:0] grid_in,
  output logic                   wr_en,
  output logic [2:0]             wr_row,
  output logic [2:0]             wr_col,
  output logic [1:0]             wr_cell,
  output logic [1:0]             grant_src,
  output logic                   busy,
  output logic                   move_done,
  output logic                   move_reject
);

  localparam int GW = ROWS * COLS * 2;
  localparam int IW = $clog2(GW);
  localparam logic [2:0] ROW_TOP = 3'(ROWS - 1);
  localparam logic [2:0] COL_MAX = 3'(COLS - 1);

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_LOC  = 2'b01;
  localparam logic [1:0] SRC_ARD  = 2'b10;
  localparam logic [1:0] SRC_RND  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_WRITE,
    S_DONE,
    S_REJECT
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_row, w_row_nxt;
  logic [2:0] r_col, w_col_nxt;
  logic [1:0] r_cell, w_cell_nxt;
  logic [1:0] r_grant, w_grant_nxt;

  function automatic logic eligible(input logic [1:0] src, input logic [1:0] turn);
    case (src)
      SRC_LOC: return turn == 2'b01;
      SRC_ARD: return turn == 2'b10;
      SRC_RND: return (turn == 2'b01) || (turn == 2'b10);
      default: return 1'b0;
    endcase
  endfunction

  // Live arbitration among this cycle's eligible requests.
  logic       w_live_vld;
  logic [1:0] w_live_src;
  logic [2:0] w_live_col;

  always_comb begin
    w_live_vld = 1'b0;
    w_live_src = SRC_NONE;
    w_live_col = '0;
    if (rnd_req && eligible(SRC_RND, turn_player)) begin
      w_live_vld = 1'b1;
      w_live_src = SRC_RND;
      w_live_col = rnd_col;
    end else if (loc_req && eligible(SRC_LOC, turn_player)) begin
      w_live_vld = 1'b1;
      w_live_src = SRC_LOC;
      w_live_col = loc_col;
    end else if (ard_req && eligible(SRC_ARD, turn_player)) begin
      w_live_vld = 1'b1;
      w_live_src = SRC_ARD;
      w_live_col = ard_col;
    end
  end

  logic       w_sel_vld;
  logic [1:0] w_sel_src;
  logic [2:0] w_sel_col;

`ifdef MOVE_ARB_PENDING_EN
  logic       r_pvld, w_pvld_nxt;
  logic [1:0] r_psrc, w_psrc_nxt;
  logic [2:0] r_pcol, w_pcol_nxt;
  logic       w_pend_ok;

  function automatic logic [1:0] rank(input logic [1:0] src);
    case (src)
      SRC_RND: return 2'd2;
      SRC_LOC: return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // A buffered entry is rechecked against the current turn; if it is no
  // longer eligible it is discarded and the live inputs get the slot.
  assign w_pend_ok = r_pvld && eligible(r_psrc, turn_player);
  assign w_sel_vld = w_pend_ok || w_live_vld;
  assign w_sel_src = w_pend_ok ? r_psrc : w_live_src;
  assign w_sel_col = w_pend_ok ? r_pcol : w_live_col;
`else
  assign w_sel_vld = w_live_vld;
  assign w_sel_src = w_live_src;
  assign w_sel_col = w_live_col;
`endif

  // Cell under the scan pointer in the live grid.
  logic [IW-1:0] w_base;
  logic [1:0]    w_cell_cur;
  assign w_base     = IW'((int'(r_row) * COLS + int'(r_col)) * 2);
  assign w_cell_cur = grid_in[w_base +: 2];

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_cell_nxt  = r_cell;
    w_grant_nxt = r_grant;
`ifdef MOVE_ARB_PENDING_EN
    w_pvld_nxt  = r_pvld;
    w_psrc_nxt  = r_psrc;
    w_pcol_nxt  = r_pcol;
`endif
    case (r_state)
      S_IDLE: begin
`ifdef MOVE_ARB_PENDING_EN
        w_pvld_nxt = 1'b0;
`endif
        if (w_sel_vld) begin
          w_col_nxt   = w_sel_col;
          w_cell_nxt  = turn_player;
          w_grant_nxt = w_sel_src;
          w_row_nxt   = '0;
          w_state_nxt = (w_sel_col > COL_MAX) ? S_REJECT : S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_cell_cur == 2'b00) begin
          w_state_nxt = S_WRITE;
        end else if (r_row == ROW_TOP) begin
          w_state_nxt = S_REJECT;
        end else begin
          w_row_nxt = r_row + 3'd1;
        end
      end
      S_WRITE: w_state_nxt = S_DONE;
      S_DONE, S_REJECT: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = SRC_NONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef MOVE_ARB_PENDING_EN
    // Only strictly higher priority replaces a held entry; ties keep the first.
    if ((r_state != S_IDLE) && w_live_vld &&
        (!r_pvld || (rank(w_live_src) > rank(r_psrc)))) begin
      w_pvld_nxt = 1'b1;
      w_psrc_nxt = w_live_src;
      w_pcol_nxt = w_live_col;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_cell  <= '0;
      r_grant <= '0;
`ifdef MOVE_ARB_PENDING_EN
      r_pvld  <= 1'b0;
      r_psrc  <= '0;
      r_pcol  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_cell  <= w_cell_nxt;
      r_grant <= w_grant_nxt;
`ifdef MOVE_ARB_PENDING_EN
      r_pvld  <= w_pvld_nxt;
      r_psrc  <= w_psrc_nxt;
      r_pcol  <= w_pcol_nxt;
`endif
    end
  end

  // The write strobe is gated by rst so a reset landing on WRITE suppresses it.
  assign wr_en       = (r_state == S_WRITE) && !rst;
  assign wr_row      = r_row;
  assign wr_col      = r_col;
  assign wr_cell     = r_cell;
  assign grant_src   = r_grant;
  assign busy        = (r_state != S_IDLE);
  assign move_done   = (r_state == S_DONE);
  assign move_reject = (r_state == S_REJECT);

endmodule

// File: tb/tb_move_arbiter.sv
module tb_move_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  turn_player;
  logic        loc_req, ard_req, rnd_req;
  logic [2:0]  loc_col, ard_col, rnd_col;
  logic [83:0] grid_in;
  logic        wr_en;
  logic [2:0]  wr_row, wr_col;
  logic [1:0]  wr_cell, grant_src;
  logic        busy, move_done, move_reject;

  int n_checks = 0;
  int n_err    = 0;

  always #10 clk = ~clk;

  move_arbiter #(.ROWS(6), .COLS(7)) dut (
    .clk(clk), .rst(rst), .turn_player(turn_player),
    .loc_req(loc_req), .loc_col(loc_col),
    .ard_req(ard_req), .ard_col(ard_col),
    .rnd_req(rnd_req), .rnd_col(rnd_col),
    .grid_in(grid_in),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_cell(wr_cell),
    .grant_src(grant_src), .busy(busy),
    .move_done(move_done), .move_reject(move_reject)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Build a grid from per-column stack heights; occupied cells get a
  // random player code.
  function automatic logic [83:0] make_grid(input int h0, input int h1, input int h2,
                                            input int h3, input int h4, input int h5,
                                            input int h6);
    logic [83:0] g;
    int h [7];
    h[0] = h0; h[1] = h1; h[2] = h2; h[3] = h3; h[4] = h4; h[5] = h5; h[6] = h6;
    g = '0;
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < h[c]; r++)
        g[(r*7+c)*2 +: 2] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    return g;
  endfunction

  // One transaction: drive the requests for one cycle, watch 10 cycles,
  // compare against the behavioural expectation.
  task automatic run_txn(input string tag, input logic [1:0] turn,
                         input logic lr, input logic [2:0] lc,
                         input logic ar, input logic [2:0] ac,
                         input logic rr, input logic [2:0] rc,
                         input logic [83:0] grid);
    logic       acc;
    logic [1:0] esrc;
    logic [2:0] ecol;
    int         k;
    logic       busy_h [10];
    logic [1:0] g0, gw;
    int wr_n, wr_c, done_n, done_c, rej_n, rej_c;
    logic [2:0] wrow, wcol;
    logic [1:0] wcell;

    // Reference: priority order rnd, loc, ard with turn rules.
    acc = 1'b0; esrc = 2'b00; ecol = 3'd0;
    if (rr && (turn == 2'b01 || turn == 2'b10)) begin acc = 1; esrc = 2'b11; ecol = rc; end
    else if (lr && turn == 2'b01) begin acc = 1; esrc = 2'b01; ecol = lc; end
    else if (ar && turn == 2'b10) begin acc = 1; esrc = 2'b10; ecol = ac; end
    k = -1;
    if (acc && ecol < 7)
      for (int r = 0; r < 6; r++)
        if (k < 0 && grid[(r*7+ecol)*2 +: 2] == 2'b00) k = r;

    wr_n = 0; wr_c = -1; done_n = 0; done_c = -1; rej_n = 0; rej_c = -1;
    wrow = 0; wcol = 0; wcell = 0; g0 = 0; gw = 0;

    @(negedge clk);
    grid_in = grid; turn_player = turn;
    loc_req = lr; loc_col = lc; ard_req = ar; ard_col = ac; rnd_req = rr; rnd_col = rc;
    @(negedge clk);
    loc_req = 0; ard_req = 0; rnd_req = 0;
    turn_player = 2'($urandom);  // must not affect the latched cell code
    for (int c = 0; c < 10; c++) begin
      busy_h[c] = busy;
      if (c == 0) g0 = grant_src;
      if (wr_en) begin wr_n++; wr_c = c; wrow = wr_row; wcol = wr_col; wcell = wr_cell; gw = grant_src; end
      if (move_done) begin done_n++; done_c = c; end
      if (move_reject) begin rej_n++; rej_c = c; end
      @(negedge clk);
    end

    if (!acc) begin
      check({tag, " idle_busy"}, 32'(busy_h[0]), 0);
      check({tag, " idle_grant"}, 32'(g0), 0);
      check({tag, " idle_wr"}, wr_n, 0);
      check({tag, " idle_done"}, done_n, 0);
      check({tag, " idle_rej"}, rej_n, 0);
    end else begin
      check({tag, " grant"}, 32'(g0), 32'(esrc));
      check({tag, " busy0"}, 32'(busy_h[0]), 1);
      if (ecol >= 7 || k < 0) begin
        check({tag, " rej_n"}, rej_n, 1);
        check({tag, " rej_cyc"}, rej_c, (ecol >= 7) ? 0 : 6);
        check({tag, " rej_wr"}, wr_n, 0);
        check({tag, " rej_done"}, done_n, 0);
        check({tag, " rej_idle"}, 32'(busy_h[(ecol >= 7) ? 1 : 7]), 0);
      end else begin
        check({tag, " wr_n"}, wr_n, 1);
        check({tag, " wr_cyc"}, wr_c, k + 1);
        check({tag, " wr_row"}, 32'(wrow), k);
        check({tag, " wr_col"}, 32'(wcol), 32'(ecol));
        check({tag, " wr_cell"}, 32'(wcell), 32'(turn));
        check({tag, " wr_grant"}, 32'(gw), 32'(esrc));
        check({tag, " done_n"}, done_n, 1);
        check({tag, " done_cyc"}, done_c, k + 2);
        check({tag, " no_rej"}, rej_n, 0);
        check({tag, " idle"}, 32'(busy_h[k+3]), 0);
      end
    end
  endtask

  initial begin
    int cnt, first_c, second_c;
    logic [2:0] second_col;

    rst = 1; turn_player = 0; grid_in = '0;
    loc_req = 0; ard_req = 0; rnd_req = 0; loc_col = 0; ard_col = 0; rnd_col = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    check("rst wr_en", 32'(wr_en), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(move_done), 0);
    check("rst reject", 32'(move_reject), 0);
    check("rst grant", 32'(grant_src), 0);
    check("rst row", 32'(wr_row), 0);
    check("rst col", 32'(wr_col), 0);
    check("rst cell", 32'(wr_cell), 0);

    // Directed cases.
    run_txn("empty_loc3", 2'b01, 1, 3'd3, 0, 0, 0, 0, '0);
    run_txn("ard_col2_h4", 2'b10, 0, 0, 1, 3'd2, 0, 0, make_grid(0, 0, 4, 0, 0, 0, 0));
    run_txn("full_col5", 2'b01, 1, 3'd5, 0, 0, 0, 0, make_grid(1, 0, 0, 0, 0, 6, 0));
    run_txn("col7_oor", 2'b01, 1, 3'd7, 0, 0, 0, 0, '0);
    run_txn("rnd_beats_loc", 2'b01, 1, 3'd4, 0, 0, 1, 3'd1, '0);
    run_txn("ard_wrong_turn", 2'b01, 0, 0, 1, 3'd2, 0, 0, '0);
    run_txn("turn00_blocks", 2'b00, 1, 3'd1, 1, 3'd1, 1, 3'd1, '0);
    run_txn("top_row", 2'b10, 0, 0, 0, 0, 1, 3'd6, make_grid(0, 0, 0, 0, 0, 0, 5));

    // Reset in SCAN cycle 2: no write or completion afterwards.
    @(negedge clk);
    grid_in = make_grid(5, 0, 0, 0, 0, 0, 0); turn_player = 2'b01;
    loc_req = 1; loc_col = 3'd0;
    @(negedge clk); loc_req = 0;
    @(negedge clk);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    check("midrst busy", 32'(busy), 0);
    check("midrst grant", 32'(grant_src), 0);
    check("midrst row", 32'(wr_row), 0);
    check("midrst cell", 32'(wr_cell), 0);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (wr_en || move_done || move_reject) cnt++;
      @(negedge clk);
    end
    check("midrst no_events", cnt, 0);

    // Request arriving while busy.
    @(negedge clk);
    grid_in = '0; turn_player = 2'b10;
    ard_req = 1; ard_col = 3'd0;
    @(negedge clk);
    ard_req = 1; ard_col = 3'd6;
    @(negedge clk);
    ard_req = 0;
    cnt = 0; first_c = -1; second_c = -1; second_col = 0;
    for (int c = 1; c < 12; c++) begin
      if (wr_en) begin
        cnt++;
        if (cnt == 1) first_c = c;
        else begin second_c = c; second_col = wr_col; end
      end
      @(negedge clk);
    end
    check("busy_req first_wr", first_c, 1);
`ifdef MOVE_ARB_PENDING_EN
    check("pend wr_count", cnt, 2);
    check("pend second_cyc", second_c, 5);
    check("pend second_col", 32'(second_col), 6);
`else
    check("drop wr_count", cnt, 1);
    check("drop second_cyc", second_c, -1);
`endif

    // Randomized transactions against the reference.
    for (int t = 0; t < 40; t++) begin
      logic [1:0] tp;
      tp = 2'($urandom);
      run_txn($sformatf("rand%0d", t), tp,
              1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
              1'($urandom), 3'($urandom),
              make_grid($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                        $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                        $urandom_range(0, 6)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/move_arbiter.md
# move_arbiter

Sequencer and arbiter for the Connect-4 board write port. It accepts column-drop requests from three sources: local debounced buttons, the Arduino UART interface, and the random-move generator on timeout. It grants one request at a time, scans the selected column bottom-up over the 84-bit grid to find the landing row, and issues a single-cycle write for that cell. It sits between the request sources and the board register, and its completion and reject pulses feed the game FSM.

## Interface
- ROWS, 6, board rows; row 0 is the bottom, row ROWS-1 is the top.
- COLS, 7, board columns; cell (r,c) occupies grid bits [(r*COLS+c)*2 +: 2].
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset; synchronous, active-high.
- turn_player  in  2  turn owner: 01 = P1, 10 = P2. Values 00 and 11 block all requests.
- loc_req  in  1  single-cycle pulse from the local buttons; honoured only when turn_player = 01.
- loc_col  in  3  column for loc_req.
- ard_req  in  1  single-cycle pulse from the Arduino; honoured only when turn_player = 10.
- ard_col  in  3  column for ard_req.
- rnd_req  in  1  single-cycle pulse from the random selector; honoured for either player.
- rnd_col  in  3  column for rnd_req.
- grid_in  in  ROWS*COLS*2  current board contents; each cell is 00 empty, 01 P1, 10 P2.
- wr_en  out  1  single-cycle board write strobe.
- wr_row  out  3  landing row.
- wr_col  out  3  landing column.
- wr_cell  out  2  cell code to write; equals the latched turn_player.
- grant_src  out  2  active source: 00 none, 01 local, 10 Arduino, 11 random. Held for the whole transaction.
- busy  out  1  high while state is not IDLE.
- move_done  out  1  single-cycle pulse after a successful write.
- move_reject  out  1  single-cycle pulse when the column is full or col ≥ COLS.

## Operation
- States: IDLE, SCAN, WRITE, DONE, REJECT.
- IDLE:
  - Samples eligible requests with fixed priority rnd > loc > ard.
  - The winner's column, turn_player and source are latched into registers.
  - Losing simultaneous requests are dropped.
  - If the latched col ≥ COLS, next state is REJECT. Otherwise next state is SCAN with row counter = 0.
- SCAN:
  - Checks cell (row, col) of the live grid_in each cycle.
  - Empty cell: next state is WRITE, and the row is held.
  - Occupied cell with row < ROWS-1: row increments and the state stays SCAN.
  - Occupied cell with row = ROWS-1: next state is REJECT.
- WRITE:
  - wr_en = 1 for exactly one cycle.
  - wr_row, wr_col and wr_cell show the latched values.
  - Next state is DONE.
- DONE: move_done = 1 for one cycle, then IDLE.
- REJECT: move_reject = 1 for one cycle, then IDLE. No write is issued.
- Requests arriving while busy = 1 are dropped, unless the pending buffer is compiled in (see Configuration).
- A request with ineligible turn_player is ignored silently: no grant, no reject.
- Row counter is 3 bits and never wraps; ROWS-1 is the terminal value.
- turn_player changes during a transaction do not affect the latched wr_cell.

## Timing
- Reset values: state IDLE; wr_en, busy, move_done, move_reject = 0; grant_src, wr_row, wr_col, wr_cell = 0; pending buffer empty.
- Cycle numbering: cycle 0 is the cycle after the acceptance edge.
- Landing row k:
  - SCAN in cycles 0..k.
  - WRITE (wr_en) in cycle k+1.
  - DONE in cycle k+2.
  - IDLE in cycle k+3.
  - Latency from request to write is k+2 clocks.
- Full column: SCAN in cycles 0..5, REJECT in cycle 6, IDLE in cycle 7.
- Out-of-range column: REJECT in cycle 0, IDLE in cycle 1.
- A new request is accepted in the first IDLE cycle, so back-to-back transactions are possible.
- All outputs are registered or state-decoded from registers; there is no combinational path from request to wr_en.
- Reset asserted mid-transaction: the next edge forces IDLE and all outputs to reset values. A wr_en already in WRITE is suppressed if rst is high in that cycle.

## Configuration
- MOVE_ARB_PENDING_EN defined:
  - Adds a one-deep pending buffer holding the highest-priority eligible request that arrives while busy.
  - A newer higher-priority request overwrites a lower-priority one; equal priority keeps the first.
  - In IDLE, a pending entry is serviced before the live inputs and is then cleared.
  - Eligibility is rechecked against turn_player at service time. A now-ineligible entry is discarded.
- MOVE_ARB_PENDING_EN undefined: requests arriving while busy are dropped and no buffer logic exists.

## Test plan
- Empty board, turn_player=01, loc_req col 3 → wr_en in cycle 1, wr_row=0, wr_col=3, wr_cell=01, move_done in cycle 2.
- Column 2 holds rows 0-3, turn_player=10, ard_req col 2 → SCAN for 5 cycles, wr_row=4, wr_cell=10, grant_src=10.
- Column 5 full, loc_req col 5 → move_reject in cycle 6, no wr_en. Then loc_req col 7 → move_reject in cycle 0.
- rnd_req col 1 and loc_req col 4 in the same cycle with turn_player=01 → only the col 1 write occurs, grant_src=11. Also: ard_req with turn_player=01 → ignored.
- Reset mid-transaction: loc_req col 0 with rows 0-4 occupied, rst asserted in SCAN cycle 2 → busy=0 next cycle, no wr_en, no move_done.
- With MOVE_ARB_PENDING_EN, ard_req col 6 arrives while busy (turn 10) → serviced right after DONE, wr_col=6. Without the macro → dropped.
